// File: rtl/gate_sequencer_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer:
// FSM encoding, gate-range codes, result-word layout and the gate-length helper.
package gate_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_LATCH,
    ST_SEND
  } state_t;

  localparam int RANGE_W = 2;
  localparam logic [RANGE_W-1:0] RANGE_1S    = 2'd0;
  localparam logic [RANGE_W-1:0] RANGE_100MS = 2'd1;
  localparam logic [RANGE_W-1:0] RANGE_10MS  = 2'd2;
  localparam logic [RANGE_W-1:0] RANGE_1MS   = 2'd3;

  // Result word: [31:30] range, [29] ovf, [28:16] seq, [15:0] count
  localparam int DATA_W    = 32;
  localparam int RANGE_LSB = 30;
  localparam int OVF_BIT   = 29;
  localparam int SEQ_LSB   = 16;
  localparam int SEQ_W     = 13;
  localparam int COUNT_LSB = 0;
  localparam int COUNT_W   = 16;

  // Gate length in clk cycles: CLK_FREQ_HZ / 10^rng
  function automatic logic [31:0] gate_cycles(input int unsigned clk_freq_hz,
                                              input logic [RANGE_W-1:0] rng);
    logic [31:0] n;
    case (rng)
      RANGE_1S:    n = clk_freq_hz;
      RANGE_100MS: n = clk_freq_hz / 10;
      RANGE_10MS:  n = clk_freq_hz / 100;
      default:     n = clk_freq_hz / 1000;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gate_sequencer_pulse_sync_edge.sv
// Brings the asynchronous pulse pin into the clk domain and emits a registered
// one-cycle pulse per rising edge; the pulse lags the pin by SYNC_STAGES+1 cycles.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // NOTE: non-blocking assignments make every stage sample its predecessor's
  // old value, so the chain shifts exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Frequency-meter measurement sequencer: gate window, saturating edge count,
// single-beat AXI-Stream result. GATE_SEQUENCER_AUTORANGE_EN enables auto gate ranging.
module gate_sequencer
  import gate_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int          CNT_W       = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [1:0]        range_sel,
  input  logic              pulse_signal,
  output logic              gate,
  output logic              busy,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  state_t              state, state_next;
  logic [31:0]         timer, gate_len;
  logic [RANGE_W-1:0]  range_q;
  logic                cont_q, stop_pending, ovf, edge_pulse;
  logic [CNT_W-1:0]    count;
  logic [SEQ_W-1:0]    seq;
  logic [DATA_W-1:0]   tdata_q, word;

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pulse_signal),
    .pulse(edge_pulse)
  );

  assign gate_len = gate_cycles(CLK_FREQ_HZ, range_q);

`ifdef GATE_SEQUENCER_AUTORANGE_EN
  localparam int unsigned LOW_THRESH = (CNT_W >= 4) ? (32'd1 << (CNT_W - 4)) : 32'd1;
  logic count_low;
  assign count_low = (32'(count) < LOW_THRESH);
`endif

  // NOTE: state_next gets its default before the case, so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start && !stop) state_next = ST_GATE;
      ST_GATE: begin
        if (stop)                          state_next = ST_IDLE;
        else if (timer == gate_len - 32'd1) state_next = ST_LATCH;
      end
      ST_LATCH: state_next = ST_SEND;
      ST_SEND: begin
        if (m_tready) state_next = (cont_q && !stop_pending && !stop) ? ST_GATE : ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    word[RANGE_LSB +: RANGE_W] = range_q;
    word[OVF_BIT]              = ovf;
    word[SEQ_LSB +: SEQ_W]     = seq;
    word[COUNT_LSB +: CNT_W]   = count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      seq          <= '0;
      range_q      <= RANGE_1S;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
      tdata_q      <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        ST_IDLE: begin
          if (state_next == ST_GATE) begin
            range_q <= range_sel;
            cont_q  <= continuous;
            timer   <= '0;
            count   <= '0;
            ovf     <= 1'b0;
          end
        end
        ST_GATE: begin
          timer <= timer + 32'd1;
          if (edge_pulse) begin
            if (count == '1) ovf   <= 1'b1;
            else             count <= count + 1'b1;
          end
        end
        ST_LATCH: begin
          tdata_q <= word;
          seq     <= seq + 1'b1;
`ifdef GATE_SEQUENCER_AUTORANGE_EN
          // Overflow shortens the gate; a near-empty count lengthens it
          if (cont_q) begin
            if (ovf && range_q != RANGE_1MS)           range_q <= range_q + 2'd1;
            else if (count_low && range_q != RANGE_1S) range_q <= range_q - 2'd1;
          end
`endif
        end
        ST_SEND: begin
          if (state_next == ST_GATE) begin
            timer <= '0;
            count <= '0;
            ovf   <= 1'b0;
`ifdef GATE_SEQUENCER_AUTORANGE_EN
            range_q <= range_q;
`else
            range_q <= range_sel;
`endif
          end
        end
        default: ;
      endcase

      if (state_next == ST_IDLE)
        stop_pending <= 1'b0;
      else if (stop && (state == ST_LATCH || state == ST_SEND))
        stop_pending <= 1'b1;
    end
  end

  assign gate     = (state == ST_GATE);
  assign busy     = (state != ST_IDLE);
  assign m_tvalid = (state == ST_SEND);
  assign m_tdata  = tdata_q;
  assign m_tlast  = 1'b1;

endmodule
